// File: rtl/pc_pkg.sv
// Shared types and default parameters for the fetch-stage PC generator.
package pc_pkg;

  localparam int          DEF_WIDTH     = 16;
  localparam int          DEF_INCR      = 2;
  localparam logic [15:0] DEF_RESET_VEC = 16'h0000;
  localparam logic [15:0] DEF_EXC_VEC   = 16'h0002;
  localparam int          DEF_RAS_DEPTH = 4;

  // Next-PC source, listed in decreasing priority
  typedef enum logic [2:0] {
    SEL_RST,
    SEL_EXC,
    SEL_HOLD,
    SEL_RET,
    SEL_CALL,
    SEL_CALLRET,
    SEL_REDIR,
    SEL_SEQ
  } pc_sel_t;

endpackage

// File: rtl/pc_gen_if.sv
// Control/status bundle between the fetch controller and the PC generator.
interface pc_gen_if #(
  parameter int WIDTH = 16
);
  logic             hold;
  logic             redirect;
  logic [WIDTH-1:0] target;
  logic             call;
  logic             ret;
  logic             exc;
  logic [WIDTH-1:0] pc_out;
  logic [WIDTH-1:0] epc;
  logic             ras_empty;
  logic             ras_full;
  logic             ras_ovf;
  logic             ras_unf;

  modport master (
    output hold, redirect, target, call, ret, exc,
    input  pc_out, epc, ras_empty, ras_full, ras_ovf, ras_unf
  );

  modport slave (
    input  hold, redirect, target, call, ret, exc,
    output pc_out, epc, ras_empty, ras_full, ras_ovf, ras_unf
  );
endinterface

// File: rtl/pc_gen_ras_stack.sv
// Circular return-address stack. A full push overwrites the oldest entry;
// push+pop together replaces the top entry (or pushes when empty).
module ras_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);
  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [PW:0]      r_cnt;
  logic             r_ovf;
  logic             r_unf;
  logic [PW-1:0]    w_ptr_inc;

  assign w_ptr_inc = r_ptr + 1'b1;
  assign top       = r_mem[r_ptr];
  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == FULL_CNT);
  assign ovf       = r_ovf;
  assign unf       = r_unf;

  // Pointer/count/flag update and entry writes; storage itself needs no reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (push && pop && !empty) begin
      r_mem[r_ptr] <= din;
    end else if (push) begin
      r_ptr            <= w_ptr_inc;
      r_mem[w_ptr_inc] <= din;
      if (full) r_ovf <= 1'b1;
      else      r_cnt <= r_cnt + 1'b1;
    end else if (pop) begin
      if (empty) begin
        r_unf <= 1'b1;
      end else begin
        r_ptr <= r_ptr - 1'b1;
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end
endmodule

// File: rtl/pc_gen.sv
// Fetch-stage program counter: priority next-PC select, PC/EPC registers, RAS.
module pc_gen
  import pc_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter int               INCR      = DEF_INCR,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(DEF_RESET_VEC),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(DEF_EXC_VEC),
  parameter int               RAS_DEPTH = DEF_RAS_DEPTH
) (
  input logic     clk,
  input logic     rst,
  pc_gen_if.slave bus
);
  localparam logic [WIDTH-1:0] INCR_W = WIDTH'(INCR);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic [WIDTH-1:0] w_seq;
  logic [WIDTH-1:0] w_top;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  pc_sel_t          w_sel;

  // Wraps modulo 2^WIDTH by construction
  assign w_seq = r_pc + INCR_W;

  // Priority decode; call without redirect degrades to a sequential step
  always_comb begin
    w_sel = SEL_SEQ;
    if (rst)                                          w_sel = SEL_RST;
    else if (bus.exc)                                 w_sel = SEL_EXC;
    else if (bus.hold)                                w_sel = SEL_HOLD;
    else if (bus.ret && !bus.call)                    w_sel = SEL_RET;
    else if (bus.call && bus.redirect && !bus.ret)    w_sel = SEL_CALL;
    else if (bus.call && bus.redirect && bus.ret)     w_sel = SEL_CALLRET;
    else if (bus.redirect)                            w_sel = SEL_REDIR;
  end

  assign w_push = (w_sel == SEL_CALL) || (w_sel == SEL_CALLRET);
  assign w_pop  = (w_sel == SEL_RET)  || (w_sel == SEL_CALLRET);

  ras_stack #(.WIDTH(WIDTH), .DEPTH(RAS_DEPTH)) u_ras (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_seq),
    .top   (w_top),
    .empty (w_empty),
    .full  (bus.ras_full),
    .ovf   (bus.ras_ovf),
    .unf   (bus.ras_unf)
  );

  // PC and exception-PC registers
  always_ff @(posedge clk) begin
    case (w_sel)
      SEL_RST: begin
        r_pc  <= RESET_VEC;
        r_epc <= '0;
      end
      SEL_EXC: begin
        r_pc  <= EXC_VEC;
        r_epc <= r_pc;
      end
      SEL_HOLD:    r_pc <= r_pc;
      SEL_RET:     r_pc <= w_empty ? w_seq : w_top;
      SEL_CALL,
      SEL_CALLRET,
      SEL_REDIR:   r_pc <= bus.target;
      default:     r_pc <= w_seq;
    endcase
  end

  assign bus.pc_out    = r_pc;
  assign bus.epc       = r_epc;
  assign bus.ras_empty = w_empty;
endmodule
